temp_poll_scheduler: RTL and testbench

Periodic poll scheduler for the TMP75 temperature reader: it times one read request per poll period, waits for the reader's data strobe, and retries when the strobe does not arrive. It holds the latest sample and a 4-sample moving average, and drives over-temperature and sensor-fault flags for the board monitor. It also services on-demand host reads. It sits between the system/host register interface and the I2C temperature reader on the 100 MHz domain.

---
 rtl/temp_poll_scheduler.sv | 172 +++++++++++++++++
 tb/tb_temp_poll_scheduler.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/temp_poll_scheduler.sv
// Periodic TMP75 poll scheduler: times read requests, retries on missing data strobes,
// and keeps latest sample, 4-sample moving average, over-temp and sensor-fault flags.
module temp_poll_scheduler #(
    parameter int unsigned POLL_CYCLES    = 100_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 200_000,
    parameter int unsigned MAX_RETRY      = 3,
    parameter logic [11:0] ALARM_HI       = 12'h500,
    parameter logic [11:0] ALARM_LO       = 12'h4B0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        host_req,
    output logic        temp_rd_en,
    input  logic [11:0] temp_data,
    input  logic        temp_data_en,
    output logic [11:0] temp_latest,
    output logic [11:0] temp_avg,
    output logic        temp_valid,
    output logic        over_temp,
    output logic        sensor_fault,
    output logic [7:0]  timeout_cnt
);
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_REQ, S_BUSY, S_UPDATE, S_TIMEOUT} state_t;

    localparam logic [31:0] POLL_LAST = 32'(POLL_CYCLES - 1);
    localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRY);

    state_t            state_q, state_d;
    logic [31:0]       pcnt_q, pcnt_d;
    logic [31:0]       tcnt_q, tcnt_d;
    logic [7:0]        retry_q, retry_d;
    logic              pending_q, pending_d;
    logic [11:0]       sample_q, sample_d;
    logic [3:0][11:0]  win_q, win_d;
    logic              win_vld_q, win_vld_d;
    logic [11:0]       latest_q, latest_d;
    logic [11:0]       avg_q, avg_d;
    logic              valid_q, valid_d;
    logic              over_q, over_d;
    logic              fault_q, fault_d;
    logic [7:0]        tocnt_q, tocnt_d;
    logic signed [13:0] sum;

    always_comb begin
        state_d   = state_q;
        pcnt_d    = pcnt_q + 32'd1;
        tcnt_d    = tcnt_q;
        retry_d   = retry_q;
        pending_d = pending_q;
        sample_d  = sample_q;
        win_d     = win_q;
        win_vld_d = win_vld_q;
        latest_d  = latest_q;
        avg_d     = avg_q;
        valid_d   = 1'b0;
        over_d    = over_q;
        fault_d   = fault_q;
        tocnt_d   = tocnt_q;
        sum       = '0;

        // Host requests that arrive mid-transaction are replayed once back in WAIT.
        if (host_req && state_q != S_IDLE && state_q != S_WAIT)
            pending_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                pcnt_d = '0;
                if (host_req) begin
                    state_d   = S_REQ;
                    pending_d = 1'b0;
                end else if (enable) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (pcnt_q >= POLL_LAST || host_req || pending_q) begin
                    state_d   = S_REQ;
                    pending_d = 1'b0;
                end else if (!enable) begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                pcnt_d  = '0;
                tcnt_d  = '0;
                state_d = S_BUSY;
            end
            S_BUSY: begin
                tcnt_d = tcnt_q + 32'd1;
                if (temp_data_en) begin
                    sample_d = temp_data;
                    state_d  = S_UPDATE;
                end else if (tcnt_q >= TO_LAST) begin
                    state_d = S_TIMEOUT;
                end
            end
            S_UPDATE: begin
                latest_d  = sample_q;
                win_d     = win_vld_q ? {win_q[2:0], sample_q} : {4{sample_q}};
                win_vld_d = 1'b1;
                sum = 14'($signed(win_d[0])) + 14'($signed(win_d[1]))
                    + 14'($signed(win_d[2])) + 14'($signed(win_d[3]));
                avg_d   = 12'(sum >>> 2);
                valid_d = 1'b1;
                retry_d = '0;
                fault_d = 1'b0;
                if ($signed(sample_q) >= $signed(ALARM_HI))
                    over_d = 1'b1;
                else if ($signed(sample_q) <= $signed(ALARM_LO))
                    over_d = 1'b0;
                state_d = (enable || pending_d) ? S_WAIT : S_IDLE;
            end
            S_TIMEOUT: begin
                if (tocnt_q != 8'hFF)
                    tocnt_d = tocnt_q + 8'd1;
                retry_d = retry_q + 8'd1;
                if (retry_d < RETRY_MAX) begin
                    state_d = S_REQ;
                end else begin
                    fault_d = 1'b1;
                    retry_d = '0;
                    state_d = (enable || pending_d) ? S_WAIT : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pcnt_q    <= '0;
            tcnt_q    <= '0;
            retry_q   <= '0;
            pending_q <= 1'b0;
            sample_q  <= '0;
            win_q     <= '0;
            win_vld_q <= 1'b0;
            latest_q  <= '0;
            avg_q     <= '0;
            valid_q   <= 1'b0;
            over_q    <= 1'b0;
            fault_q   <= 1'b0;
            tocnt_q   <= '0;
        end else begin
            state_q   <= state_d;
            pcnt_q    <= pcnt_d;
            tcnt_q    <= tcnt_d;
            retry_q   <= retry_d;
            pending_q <= pending_d;
            sample_q  <= sample_d;
            win_q     <= win_d;
            win_vld_q <= win_vld_d;
            latest_q  <= latest_d;
            avg_q     <= avg_d;
            valid_q   <= valid_d;
            over_q    <= over_d;
            fault_q   <= fault_d;
            tocnt_q   <= tocnt_d;
        end
    end

    assign temp_rd_en   = (state_q == S_REQ);
    assign temp_latest  = latest_q;
    assign temp_avg     = avg_q;
    assign temp_valid   = valid_q;
    assign over_temp    = over_q;
    assign sensor_fault = fault_q;
    assign timeout_cnt  = tocnt_q;
endmodule

// File: tb/tb_temp_poll_scheduler.sv
// Directed bench for temp_poll_scheduler with a scoreboard of expected sample updates.
module tb_temp_poll_scheduler;
    localparam int POLL = 100;
    localparam int TOUT = 20;
    localparam logic [11:0] HI = 12'h500;
    localparam logic [11:0] LO = 12'h4B0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        host_req = 1'b0;
    logic        temp_rd_en;
    logic [11:0] temp_data = '0;
    logic        temp_data_en = 1'b0;
    logic [11:0] temp_latest;
    logic [11:0] temp_avg;
    logic        temp_valid;
    logic        over_temp;
    logic        sensor_fault;
    logic [7:0]  timeout_cnt;

    temp_poll_scheduler #(
        .POLL_CYCLES(POLL), .TIMEOUT_CYCLES(TOUT), .MAX_RETRY(2),
        .ALARM_HI(HI), .ALARM_LO(LO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .host_req(host_req),
        .temp_rd_en(temp_rd_en), .temp_data(temp_data), .temp_data_en(temp_data_en),
        .temp_latest(temp_latest), .temp_avg(temp_avg), .temp_valid(temp_valid),
        .over_temp(over_temp), .sensor_fault(sensor_fault), .timeout_cnt(timeout_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [11:0] lat;
        logic [11:0] avg;
        logic        ot;
    } exp_t;
    exp_t exp_q[$];

    logic [11:0] mw[4];
    bit          mfirst = 1'b1;
    logic        mot = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_push(input logic [11:0] s);
        int   tot;
        exp_t e;
        if (mfirst) begin
            for (int i = 0; i < 4; i++) mw[i] = s;
            mfirst = 1'b0;
        end else begin
            for (int i = 3; i > 0; i--) mw[i] = mw[i-1];
            mw[0] = s;
        end
        tot = 0;
        for (int i = 0; i < 4; i++) tot += int'($signed(mw[i]));
        tot = tot >>> 2;
        if ($signed(s) >= $signed(HI)) mot = 1'b1;
        else if ($signed(s) <= $signed(LO)) mot = 1'b0;
        e.lat = s;
        e.avg = tot[11:0];
        e.ot  = mot;
        exp_q.push_back(e);
    endtask

    // Scoreboard: every temp_valid pulse must match the oldest expected update.
    always @(negedge clk) begin
        if (rst_n && temp_valid) begin
            chk("valid_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_latest", 32'(temp_latest), 32'(e.lat));
                chk("sb_avg", 32'(temp_avg), 32'(e.avg));
                chk("sb_over", 32'(over_temp), 32'(e.ot));
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_rd(output int c);
        c = -1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (temp_rd_en) begin
                c = cyc;
                break;
            end
        end
        chk("rd_seen", 32'(c >= 0), 32'd1);
    endtask

    // Reader model: strobe data `dly` cycles after now; checks the 2-cycle update latency.
    task automatic respond(input int dly, input logic [11:0] s, output int sc);
        cycles(dly);
        sc = cyc;
        temp_data    = s;
        temp_data_en = 1'b1;
        model_push(s);
        @(negedge clk);
        temp_data_en = 1'b0;
        @(negedge clk);
        chk("valid_latency", 32'(temp_valid), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rd_en"}, 32'(temp_rd_en), 32'd0);
        chk({tag, "_latest"}, 32'(temp_latest), 32'd0);
        chk({tag, "_avg"}, 32'(temp_avg), 32'd0);
        chk({tag, "_valid"}, 32'(temp_valid), 32'd0);
        chk({tag, "_over"}, 32'(over_temp), 32'd0);
        chk({tag, "_fault"}, 32'(sensor_fault), 32'd0);
        chk({tag, "_tocnt"}, 32'(timeout_cnt), 32'd0);
    endtask

    int r1, r2, r3, e0, sc, cnt;
    logic [11:0] avg_seq[3] = '{12'hFF0, 12'h000, 12'h010};
    logic [11:0] hys_s[4]   = '{12'h4FF, 12'h500, 12'h4C0, 12'h4B0};
    logic        hys_o[4]   = '{1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        // Reset state
        cycles(3);
        check_all_zero("reset");
        rst_n = 1'b1;

        // No requests while disabled
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (temp_rd_en) cnt++;
        end
        chk("idle_no_rd", 32'(cnt), 32'd0);

        // Enable: first request POLL+1 later, silent reader -> retry, then fault
        enable = 1'b1;
        e0 = cyc;
        wait_rd(r1);
        chk("first_poll_delay", 32'(r1 - e0), 32'(POLL + 1));
        wait_rd(r2);
        chk("retry_spacing", 32'(r2 - r1), 32'(TOUT + 2));
        cycles(23);
        chk("fault_set", 32'(sensor_fault), 32'd1);
        chk("timeout_cnt", 32'(timeout_cnt), 32'd2);
        chk("no_update_on_fault", 32'(temp_latest), 32'd0);

        // Recovery and steady polling at 25 C
        wait_rd(r3);
        chk("poll_after_fault", 32'(r3 - r2), 32'(POLL + 1));
        respond(10, 12'h190, sc);
        chk("fault_clear", 32'(sensor_fault), 32'd0);
        wait_rd(r1);
        chk("poll_spacing", 32'(r1 - r3), 32'(POLL + 1));
        respond(10, 12'h190, sc);
        chk("steady_avg", 32'(temp_avg), 32'h190);

        // Averaging with negative samples
        foreach (avg_seq[i]) begin
            r3 = r1;
            wait_rd(r1);
            chk("poll_spacing_avg", 32'(r1 - r3), 32'(POLL + 1));
            respond(8, avg_seq[i], sc);
        end
        chk("avg_final", 32'(temp_avg), 32'h064);

        // Hysteresis
        foreach (hys_s[i]) begin
            wait_rd(r1);
            respond(5, hys_s[i], sc);
            chk("hyst_over", 32'(over_temp), 32'(hys_o[i]));
        end

        // Host request during BUSY: replayed 2 cycles after UPDATE
        wait_rd(r1);
        cycles(3);
        host_req = 1'b1;
        @(negedge clk);
        host_req = 1'b0;
        respond(6, 12'h190, sc);
        wait_rd(r2);
        chk("host_replay", 32'(r2 - sc), 32'd3);
        respond(5, 12'h190, sc);
        wait_rd(r3);
        chk("period_restart", 32'(r3 - r2), 32'(POLL + 1));
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        // Reset mid-BUSY, then a late strobe must be ignored
        cycles(5);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        exp_q.delete();
        mfirst = 1'b1;
        mot = 1'b0;
        enable = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        cycles(2);
        temp_data = 12'h321;
        temp_data_en = 1'b1;
        @(negedge clk);
        temp_data_en = 1'b0;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (temp_valid || temp_rd_en) cnt++;
        end
        chk("late_strobe_ignored", 32'(cnt), 32'd0);
        chk("late_latest", 32'(temp_latest), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
